// File: rtl/mag_ctrl_seq.sv
// Magnetron sequencer: IDLE/COOK/PAUSED/DONE with duty-cycled power,
// pause/resume and an end-of-cook beep.
module mag_ctrl_seq #(
   parameter  int PWR_LEVELS  = 4,
   parameter  int DUTY_PERIOD = 16,
   parameter  int BEEP_CYCLES = 8,
   localparam int PSEL_W = ($clog2(PWR_LEVELS) > 1) ? $clog2(PWR_LEVELS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              startn,
   input  logic              stopn,
   input  logic              clearn,
   input  logic              door_closed,
   input  logic              timer_done,
   input  logic [PSEL_W-1:0] power_sel,
   output logic              mag_on,
   output logic [1:0]        state,
   output logic              beep
);

   localparam int DCNT_W = ($clog2(DUTY_PERIOD) > 1) ? $clog2(DUTY_PERIOD) : 1;
   localparam int BCNT_W = $clog2(BEEP_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      COOK   = 2'd1,
      PAUSED = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic                startn_q;
   logic [PSEL_W-1:0]   lvl_q, lvl_d;
   logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
   logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
   logic                mag_q, mag_d;
   logic                beep_q, beep_d;
   logic                start_ev;
   logic                enter_cook;
   logic [PSEL_W-1:0]   psel_c;
   logic [31:0]         on_cyc;

   assign start_ev = startn_q & ~startn;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         startn_q <= 1'b1;
         lvl_q    <= '0;
         dcnt_q   <= '0;
         bcnt_q   <= '0;
         mag_q    <= 1'b0;
         beep_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         startn_q <= startn;
         lvl_q    <= lvl_d;
         dcnt_q   <= dcnt_d;
         bcnt_q   <= bcnt_d;
         mag_q    <= mag_d;
         beep_q   <= beep_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start_ev && door_closed && !timer_done && stopn && clearn)
               state_d = COOK;
         end
         COOK: begin
            if (!clearn)
               state_d = IDLE;
            else if (!door_closed || !stopn)
               state_d = PAUSED;
            else if (timer_done)
               state_d = DONE;
         end
         PAUSED: begin
            if (!clearn || !stopn)
               state_d = IDLE;
            else if (start_ev && door_closed && !timer_done)
               state_d = COOK;
         end
         DONE: begin
            if (!clearn || !door_closed)
               state_d = IDLE;
            else if (bcnt_q == BCNT_W'(BEEP_CYCLES))
               state_d = IDLE;
         end
      endcase
   end

   // Datapath: power latch, duty counter, beep counter, registered enables
   always_comb begin
      psel_c = power_sel;
      if (32'(power_sel) >= 32'(PWR_LEVELS))
         psel_c = PSEL_W'(PWR_LEVELS - 1);
      enter_cook = (state_d == COOK) && (state_q != COOK);
      lvl_d  = enter_cook ? psel_c : lvl_q;
      dcnt_d = '0;
      if (state_d == COOK && !enter_cook) begin
         if (dcnt_q == DCNT_W'(DUTY_PERIOD - 1))
            dcnt_d = '0;
         else
            dcnt_d = dcnt_q + DCNT_W'(1);
      end
      bcnt_d = '0;
      if (state_d == DONE)
         bcnt_d = (state_q == DONE) ? bcnt_q + BCNT_W'(1) : BCNT_W'(1);
      on_cyc = ((32'(lvl_d) + 32'd1) * 32'(DUTY_PERIOD)) / 32'(PWR_LEVELS);
      mag_d  = (state_d == COOK) && (32'(dcnt_d) < on_cyc);
      beep_d = (state_d == DONE);
   end

   // Door gates the magnetron combinationally, no clock latency
   always_comb begin
      state  = state_q;
      mag_on = mag_q & door_closed;
      beep   = beep_q;
   end

endmodule

// File: tb/tb_mag_ctrl_seq.sv
// Scoreboard bench for mag_ctrl_seq: a cycle model pushes expected
// outputs per edge, which are popped and compared against the DUT.
module tb_mag_ctrl_seq;

   localparam int NLVL = 4;
   localparam int DP   = 16;
   localparam int BC   = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       startn, stopn, clearn, door_closed, timer_done;
   logic [1:0] power_sel;
   logic       mag_on, beep;
   logic [1:0] state;

   typedef struct {
      logic [1:0] st;
      logic       mag;
      logic       bp;
   } exp_t;

   exp_t sb_q[$];

   int n_chk  = 0;
   int n_fail = 0;

   int m_state;
   bit m_prev;
   int m_lvl;
   int m_t;
   int m_bc;

   always #5 clk = ~clk;

   mag_ctrl_seq #(
      .PWR_LEVELS (NLVL),
      .DUTY_PERIOD(DP),
      .BEEP_CYCLES(BC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .startn     (startn),
      .stopn      (stopn),
      .clearn     (clearn),
      .door_closed(door_closed),
      .timer_done (timer_done),
      .power_sel  (power_sel),
      .mag_on     (mag_on),
      .state      (state),
      .beep       (beep)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void go_cook();
      m_state = 1;
      m_lvl   = (int'(power_sel) > NLVL - 1) ? NLVL - 1 : int'(power_sel);
      m_t     = 0;
   endfunction

   // Reference behaviour at one rising edge, from the inputs seen at that edge
   function automatic void model_edge();
      bit ev;
      if (rst) begin
         m_state = 0; m_prev = 1'b1; m_lvl = 0; m_t = 0; m_bc = 0;
         return;
      end
      ev = m_prev && !startn;
      m_prev = startn;
      case (m_state)
         0: if (ev && door_closed && !timer_done && stopn && clearn) go_cook();
         1: begin
            if (!clearn) m_state = 0;
            else if (!door_closed || !stopn) m_state = 2;
            else if (timer_done) begin m_state = 3; m_bc = 1; end
            else m_t++;
         end
         2: begin
            if (!clearn || !stopn) m_state = 0;
            else if (ev && door_closed && !timer_done) go_cook();
         end
         default: begin
            if (!clearn || !door_closed) m_state = 0;
            else if (m_bc == BC) m_state = 0;
            else m_bc++;
         end
      endcase
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      int on;
      on = ((m_lvl + 1) * DP) / NLVL;
      e.st  = 2'(m_state);
      e.mag = (m_state == 1) && ((m_t % DP) < on) && door_closed;
      e.bp  = (m_state == 3);
      return e;
   endfunction

   task automatic compare_out();
      exp_t e;
      e = sb_q.pop_front();
      chk("state", int'(state), int'(e.st));
      chk("mag_on", int'(mag_on), int'(e.mag));
      chk("beep", int'(beep), int'(e.bp));
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      sb_q.push_back(model_out());
      compare_out();
   endtask

   // Combinational check between edges (door interlock)
   task automatic settle();
      #1;
      sb_q.push_back(model_out());
      compare_out();
   endtask

   int cnt;
   int entries;
   logic [1:0] prev_st;

   initial begin
      rst = 1'b1; startn = 1'b0; stopn = 1'b0; clearn = 1'b0;
      door_closed = 1'b1; timer_done = 1'b0; power_sel = 2'd0;
      m_state = 0; m_prev = 1'b1; m_lvl = 0; m_t = 0; m_bc = 0;
      #2;
      tick(); tick();
      rst = 1'b0;
      tick();
      stopn = 1'b1; clearn = 1'b1;
      tick(); tick();
      chk("no_start_after_rst", int'(state), 0);
      startn = 1'b1;
      tick();

      // Start at level 1, 8 on / 8 off, power change mid-cook ignored
      power_sel = 2'd1; startn = 1'b0;
      cnt = 0;
      for (int i = 0; i < 48; i++) begin
         tick();
         if (i == 0) begin
            chk("start_state", int'(state), 1);
            startn = 1'b1;
         end
         if (i == 20) power_sel = 2'd3;
         if (i == 7 || i == 39) chk("duty_last_on", int'(mag_on), 1);
         if (i == 8 || i == 31) chk("duty_first_off", int'(mag_on), 0);
         cnt += int'(mag_on);
      end
      chk("duty_lvl1_ones", cnt, 24);

      // Door opens: immediate drop, then PAUSED
      door_closed = 1'b0;
      settle();
      chk("door_drop", int'(mag_on), 0);
      tick();
      chk("door_paused", int'(state), 2);
      door_closed = 1'b1;
      tick(); tick(); tick();
      chk("closed_stays_paused", int'(state), 2);
      startn = 1'b0;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (i == 0) startn = 1'b1;
         cnt += int'(mag_on);
      end
      chk("lvl3_continuous", cnt, 20);

      // Timer done: 8-cycle beep, start ignored in DONE
      timer_done = 1'b1;
      cnt = 0;
      for (int i = 0; i < 11; i++) begin
         tick();
         if (i == 0) begin
            chk("done_state", int'(state), 3);
            timer_done = 1'b0;
         end
         if (i == 2) startn = 1'b0;
         if (i == 3) startn = 1'b1;
         cnt += int'(beep);
      end
      chk("beep_len", cnt, BC);
      chk("done_to_idle", int'(state), 0);

      // Stop twice
      power_sel = 2'd2; startn = 1'b0;
      tick(); startn = 1'b1;
      tick(); tick();
      stopn = 1'b0; tick();
      chk("stop1_paused", int'(state), 2);
      stopn = 1'b1; tick();
      stopn = 1'b0; tick();
      chk("stop2_idle", int'(state), 0);
      stopn = 1'b1; tick();

      // Clear beats start in PAUSED
      startn = 1'b0; tick(); startn = 1'b1; tick();
      stopn = 1'b0; tick(); stopn = 1'b1; tick();
      clearn = 1'b0; startn = 1'b0; tick();
      chk("clear_vs_start", int'(state), 0);
      clearn = 1'b1; startn = 1'b1; tick();

      // Start blocked by open door / expired timer
      door_closed = 1'b0; startn = 1'b0; tick();
      chk("blk_door", int'(state), 0);
      door_closed = 1'b1; startn = 1'b1; tick();
      timer_done = 1'b1; startn = 1'b0; tick();
      chk("blk_timer", int'(state), 0);
      timer_done = 1'b0; startn = 1'b1; tick();

      // Held start: exactly one start event
      power_sel = 2'd0; startn = 1'b0;
      entries = 0; prev_st = state;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (i == 5) stopn = 1'b0;
         if (i == 6) stopn = 1'b1;
         if (state == 2'd1 && prev_st != 2'd1) entries++;
         prev_st = state;
      end
      chk("held_start_once", entries, 1);
      startn = 1'b1; tick();
      clearn = 1'b0; tick(); clearn = 1'b1; tick();

      // Reset in the middle of cooking
      startn = 1'b0; tick(); startn = 1'b1; tick(); tick();
      rst = 1'b1; tick();
      chk("rst_mid_cook", int'(state), 0);
      rst = 1'b0; tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mag_ctrl_seq.md
# mag_ctrl_seq

Clocked, parametrised successor to the microwave magnetron controller. It is a four-state sequencer (IDLE, COOK, PAUSED, DONE) driven by the same active-low front-panel buttons, the door interlock and the timer-done flag. It adds selectable power levels, implemented as a duty-cycled `mag_on`, plus pause/resume and an end-of-cook beep. It sits between the button/timer logic and the magnetron driver.

## Interface
- `PWR_LEVELS`, 4: number of power levels, ≥2.
- `DUTY_PERIOD`, 16: length in cycles of one duty window, ≥ `PWR_LEVELS`.
- `BEEP_CYCLES`, 8: length in cycles of the `beep` pulse in DONE, ≥1.
- Derived: `PSEL_W = max(1, clog2(PWR_LEVELS))`.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `startn` in 1: start button, active-low; only its falling edge acts.
- `stopn` in 1: stop button, active-low, level-sensitive.
- `clearn` in 1: clear button, active-low, level-sensitive.
- `door_closed` in 1: 1 means the door is closed.
- `timer_done` in 1: 1 means the cook timer has expired.
- `power_sel` in `PSEL_W`: requested power level, 0 = lowest. Values ≥ `PWR_LEVELS` clamp to `PWR_LEVELS-1`.
- `mag_on` out 1: magnetron enable.
- `state` out 2: current state. IDLE=0, COOK=1, PAUSED=2, DONE=3.
- `beep` out 1: high during the DONE beep window.

## Operation
**Start detection**
- `start_ev` = previous registered `startn` was 1 AND current `startn` is 0.
- The previous-`startn` register resets to 1.

**Transitions** (evaluated in priority order, top wins)
- IDLE:
  - `start_ev` & `door_closed` & !`timer_done` & `stopn` & `clearn` → COOK.
  - Otherwise stay in IDLE.
- COOK:
  - !`clearn` → IDLE.
  - !`door_closed` → PAUSED.
  - !`stopn` → PAUSED.
  - `timer_done` → DONE.
- PAUSED:
  - !`clearn` → IDLE.
  - !`stopn` → IDLE (second stop cancels).
  - `start_ev` & `door_closed` & !`timer_done` → COOK.
  - `timer_done` alone does nothing.
- DONE:
  - !`clearn` or !`door_closed` → IDLE.
  - Otherwise, after `BEEP_CYCLES` cycles in DONE → IDLE.
  - `start_ev` is ignored.

**Power latch**
- `power_sel` (clamped) is captured into `lvl` on every transition into COOK.
- `lvl` holds during COOK; changes on `power_sel` are ignored while cooking.
- `lvl` resets to 0.

**Duty counter `dcnt`**
- Width `clog2(DUTY_PERIOD)`.
- Cleared to 0 on entry to COOK.
- Increments each cycle in COOK and wraps `DUTY_PERIOD-1` → 0.
- Held at 0 in all other states.

**On-time**
- `on_cycles = ((lvl+1)*DUTY_PERIOD)/PWR_LEVELS`, computed with integer floor and wide enough not to overflow.
- The top level gives `on_cycles = DUTY_PERIOD`, i.e. continuous on.

**`mag_on`**
- `mag_q` is registered: next `mag_q` = (next state == COOK) & (next `dcnt` < `on_cycles` of next `lvl`).
- `mag_on = mag_q & door_closed`. This combinational AND is the interlock; the door drops the magnetron with no clock latency.

**`beep`**
- Registered; high exactly `BEEP_CYCLES` cycles starting on entry to DONE.
- Low outside DONE, and cleared if DONE exits early.

## Timing
**Reset values** (in effect while `rst` is high and on the first edge after it falls):
- `state` = 0, `mag_on` = 0, `beep` = 0, `dcnt` = 0, `lvl` = 0, previous `startn` = 1.
- `rst` asserted mid-operation returns to IDLE on the next edge, even during COOK.

**Latency**
- An edge that samples `start_ev` in IDLE/PAUSED gives `state` = COOK and `mag_on` = 1 (for `lvl` ≥ 0) in the following cycle.
- Exits from COOK (stop, clear, timer): `state` and `mag_on` update one cycle later.
- Door open: `mag_on` drops in the same cycle; `state` becomes PAUSED one edge later.

**Duty pattern**
- With defaults and `lvl` = 1: `mag_on` is high for cycles 0–7 and low for 8–15 of each 16-cycle window, measured from COOK entry.

**Beep**
- `beep` is high for cycles 1..`BEEP_CYCLES` after the edge that enters DONE.
- `state` = IDLE on the edge after the last beep cycle.

**Other rules**
- `startn` held low generates exactly one `start_ev`. A new start requires `startn` to return high for at least one sampled cycle.
- Simultaneous events resolve purely by the priority order above.

## Test plan
- **Reset:** `rst` = 1 for 2 cycles with all buttons pressed → `state` = 0, `mag_on` = 0, `beep` = 0. No start occurs when `rst` falls with `startn` still low.
- **Start at `power_sel` = 1:** `startn` low for 1 cycle, door closed → next cycle `state` = 1. `mag_on` pattern is 8 high / 8 low, repeating for 3 windows. Change `power_sel` to 3 mid-cook → pattern unchanged.
- **Door interlock and resume:**
  - `door_closed` = 0 mid-cook → `mag_on` = 0 in the same cycle; `state` = 2 next cycle.
  - Close the door → stays at 2.
  - `start_ev` with `power_sel` = 3 → `state` = 1, `mag_on` continuously high, `dcnt` restarted at 0.
- **Timer done:** `timer_done` = 1 in COOK → `state` = 3, `mag_on` = 0, `beep` high exactly 8 cycles, then `state` = 0. A `start_ev` during DONE is ignored.
- **Stop twice:** `stopn` low in COOK → PAUSED. Release, then `stopn` low again → IDLE.
- **Simultaneous events and start blocking:**
  - In PAUSED, `clearn` = 0 and `start_ev` in the same cycle → IDLE.
  - In IDLE, `start_ev` with `door_closed` = 0 or `timer_done` = 1 → stays IDLE.
  - `startn` held low for 20 cycles gives a single start.
